// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of a single combinational program ROM.
// Fetch (F_*) and data (D_*) requesters share one ROM access per cycle;
// ties are broken round-robin. Each port owns a one-entry registered
// response slot with a valid/ready handshake. Out-of-range addresses
// return zero data, set the response error flag and bump a saturating
// error counter.
module rom_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  // fetch port
  input  logic              F_REQ,
  input  logic [ADDR_W-1:0] F_ADDR,
  output logic              F_GNT,
  output logic              F_RVALID,
  output logic [DATA_W-1:0] F_RDATA,
  output logic              F_RERR,
  input  logic              F_RREADY,
  // data port
  input  logic              D_REQ,
  input  logic [ADDR_W-1:0] D_ADDR,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              D_RERR,
  input  logic              D_RREADY,
  // ROM side
  output logic [ADDR_W-1:0] ROM_ADDRESS,
  input  logic [DATA_W-1:0] ROM_VALUE,
  output logic [CNT_W-1:0]  ERR_COUNT
);

  // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]  DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic              f_elig, d_elig;
  logic              f_win, d_win;
  logic [ADDR_W-1:0] rom_addr;
  logic              oob;
  logic [DATA_W-1:0] resp_data;

  // last_d_q = 1 means the data port won the most recent grant.
  logic              last_d_q, last_d_d;
  logic              f_rvalid_q, f_rvalid_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic              f_rerr_q, f_rerr_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_rerr_q, d_rerr_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Eligibility, round-robin winner selection and ROM address mux.
  always_comb begin
    f_elig = F_REQ & (~f_rvalid_q | F_RREADY);
    d_elig = D_REQ & (~d_rvalid_q | D_RREADY);
    f_win  = 1'b0;
    d_win  = 1'b0;
    if (!RESET) begin
      if (f_elig && d_elig) begin
        f_win = last_d_q;
        d_win = ~last_d_q;
      end else begin
        f_win = f_elig;
        d_win = d_elig;
      end
    end
    if (f_win) begin
      rom_addr = F_ADDR;
    end else if (d_win) begin
      rom_addr = D_ADDR;
    end else begin
      rom_addr = '0;
    end
    oob       = ({1'b0, rom_addr} >= DepthExt);
    resp_data = oob ? '0 : ROM_VALUE;
  end

  // Next state of the response slots, round-robin pointer and error counter.
  always_comb begin
    f_rvalid_d = f_rvalid_q;
    f_rdata_d  = f_rdata_q;
    f_rerr_d   = f_rerr_q;
    d_rvalid_d = d_rvalid_q;
    d_rdata_d  = d_rdata_q;
    d_rerr_d   = d_rerr_q;
    last_d_d   = last_d_q;
    err_cnt_d  = err_cnt_q;

    // A grant on a draining slot refills it directly: no bubble.
    if (f_win) begin
      f_rvalid_d = 1'b1;
      f_rdata_d  = resp_data;
      f_rerr_d   = oob;
    end else if (f_rvalid_q && F_RREADY) begin
      f_rvalid_d = 1'b0;
    end

    if (d_win) begin
      d_rvalid_d = 1'b1;
      d_rdata_d  = resp_data;
      d_rerr_d   = oob;
    end else if (d_rvalid_q && D_RREADY) begin
      d_rvalid_d = 1'b0;
    end

    if (f_win) begin
      last_d_d = 1'b0;
    end else if (d_win) begin
      last_d_d = 1'b1;
    end

    if ((f_win || d_win) && oob && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset leaves LAST = D so fetch wins the first tie.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      f_rerr_q   <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_rerr_q   <= 1'b0;
      last_d_q   <= 1'b1;
      err_cnt_q  <= '0;
    end else begin
      f_rvalid_q <= f_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      f_rerr_q   <= f_rerr_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      d_rerr_q   <= d_rerr_d;
      last_d_q   <= last_d_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign F_GNT       = f_win;
  assign D_GNT       = d_win;
  assign ROM_ADDRESS = rom_addr;
  assign F_RVALID    = f_rvalid_q;
  assign F_RDATA     = f_rdata_q;
  assign F_RERR      = f_rerr_q;
  assign D_RVALID    = d_rvalid_q;
  assign D_RDATA     = d_rdata_q;
  assign D_RERR      = d_rerr_q;
  assign ERR_COUNT   = err_cnt_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_rom_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 8;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              F_REQ, F_GNT, F_RVALID, F_RERR, F_RREADY;
  logic [ADDR_W-1:0] F_ADDR;
  logic [DATA_W-1:0] F_RDATA;
  logic              D_REQ, D_GNT, D_RVALID, D_RERR, D_RREADY;
  logic [ADDR_W-1:0] D_ADDR;
  logic [DATA_W-1:0] D_RDATA;
  logic [ADDR_W-1:0] ROM_ADDRESS;
  logic [DATA_W-1:0] ROM_VALUE;
  logic [CNT_W-1:0]  ERR_COUNT;

  logic [DATA_W-1:0] rom [DEPTH];

  // Out-of-range reads return junk so the DUT's zeroing is visible.
  assign ROM_VALUE = (ROM_ADDRESS < DEPTH) ? rom[ROM_ADDRESS[2:0]] : 16'hDEAD;

  always #5 CLK = ~CLK;

  rom_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_GNT(F_GNT), .F_RVALID(F_RVALID),
    .F_RDATA(F_RDATA), .F_RERR(F_RERR), .F_RREADY(F_RREADY),
    .D_REQ(D_REQ), .D_ADDR(D_ADDR), .D_GNT(D_GNT), .D_RVALID(D_RVALID),
    .D_RDATA(D_RDATA), .D_RERR(D_RERR), .D_RREADY(D_RREADY),
    .ROM_ADDRESS(ROM_ADDRESS), .ROM_VALUE(ROM_VALUE), .ERR_COUNT(ERR_COUNT)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-port pending response plus who was served last.
  bit                m_fv, m_dv, m_fe, m_de, m_last_d;
  logic [DATA_W-1:0] m_fd, m_dd;
  int                m_cnt;
  int                m_win; // 0 none, 1 fetch, 2 data

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fv = 0; m_dv = 0; m_fe = 0; m_de = 0;
    m_fd = '0; m_dd = '0;
    m_last_d = 1; m_cnt = 0; m_win = 0;
  endtask

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return (a < DEPTH) ? rom[a[2:0]] : '0;
  endfunction

  // Called just after a falling edge with inputs already driven; checks
  // the cycle, advances the model and returns at the next falling edge.
  task automatic step();
    bit fe, de;
    logic [ADDR_W-1:0] a;
    #1;
    chk("f_rvalid", F_RVALID, m_fv);
    chk("f_rdata", F_RDATA, m_fd);
    chk("f_rerr", F_RERR, m_fe);
    chk("d_rvalid", D_RVALID, m_dv);
    chk("d_rdata", D_RDATA, m_dd);
    chk("d_rerr", D_RERR, m_de);
    chk("err_count", ERR_COUNT, m_cnt);
    m_win = 0;
    if (!RESET) begin
      fe = F_REQ && (!m_fv || F_RREADY);
      de = D_REQ && (!m_dv || D_RREADY);
      if (fe && de) m_win = m_last_d ? 1 : 2;
      else if (fe)  m_win = 1;
      else if (de)  m_win = 2;
    end
    a = (m_win == 1) ? F_ADDR : (m_win == 2) ? D_ADDR : '0;
    chk("f_gnt", F_GNT, m_win == 1);
    chk("d_gnt", D_GNT, m_win == 2);
    chk("rom_address", ROM_ADDRESS, a);
    if (!RESET) begin
      if (m_win == 1) begin
        m_fv = 1; m_fd = rd(a); m_fe = (a >= DEPTH);
      end else if (m_fv && F_RREADY) m_fv = 0;
      if (m_win == 2) begin
        m_dv = 1; m_dd = rd(a); m_de = (a >= DEPTH);
      end else if (m_dv && D_RREADY) m_dv = 0;
      if (m_win != 0) begin
        m_last_d = (m_win == 2);
        if (a >= DEPTH && m_cnt < 255) m_cnt++;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1; F_REQ = 1; D_REQ = 1; F_ADDR = 8'd4; D_ADDR = 8'd5;
    F_RREADY = 1; D_RREADY = 1;
    model_reset();
    step();
    step();
    RESET = 0; F_REQ = 0; D_REQ = 0;
  endtask

  bit f_hold, d_hold;

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'($urandom);
    RESET = 1; F_REQ = 0; D_REQ = 0; F_ADDR = '0; D_ADDR = '0;
    F_RREADY = 0; D_RREADY = 0;
    model_reset();
    @(negedge CLK);

    // Reset with both requests high: nothing granted, everything cleared.
    do_reset();

    // Single fetch from address 3.
    F_REQ = 1; F_ADDR = 8'd3; F_RREADY = 1;
    #1 chk("single_gnt", F_GNT, 1);
    step();
    F_REQ = 0;
    #1 chk("single_rvalid", F_RVALID, 1);
    chk("single_rdata", F_RDATA, rom[3]);
    step();
    #1 chk("single_drop", F_RVALID, 0);
    step();

    // Contention after reset: F,D,F,D...
    do_reset();
    F_REQ = 1; D_REQ = 1; F_ADDR = 8'd1; D_ADDR = 8'd2;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_f_gnt", F_GNT, (k % 2) == 0);
      chk("rr_d_gnt", D_GNT, (k % 2) == 1);
      step();
    end
    F_REQ = 0; D_REQ = 0;
    step();

    // Backpressure on the data port.
    D_REQ = 1; D_ADDR = 8'd5; D_RREADY = 0;
    step();
    F_REQ = 1; F_ADDR = 8'd2; F_RREADY = 1; D_ADDR = 8'd6;
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_f_gnt", F_GNT, 1);
      chk("bp_d_gnt", D_GNT, 0);
      chk("bp_d_hold", D_RDATA, rom[5]);
      step();
    end
    D_RREADY = 1;
    #1 chk("bp_release_gnt", D_GNT, 1);
    step();
    F_REQ = 0; D_REQ = 0;
    step();

    // Out-of-range accesses and counter saturation.
    do_reset();
    D_REQ = 1; D_ADDR = 8'd8; D_RREADY = 1;
    step();
    D_ADDR = 8'd255;
    #1 chk("range8_rerr", D_RERR, 1);
    chk("range8_rdata", D_RDATA, 0);
    step();
    D_REQ = 0;
    #1 chk("range255_rerr", D_RERR, 1);
    chk("range255_rdata", D_RDATA, 0);
    chk("range_count", ERR_COUNT, 2);
    step();
    D_REQ = 1; D_ADDR = 8'd200;
    for (int k = 0; k < 260; k++) step();
    D_REQ = 0;
    step();
    #1 chk("sat_count", ERR_COUNT, 255);
    step();

    // Mid-operation reset discards the in-flight response.
    F_REQ = 1; F_ADDR = 8'd7; F_RREADY = 0;
    step();
    F_REQ = 0;
    RESET = 1;
    #1 chk("async_rvalid", F_RVALID, 0);
    model_reset();
    step();
    RESET = 0; F_REQ = 1; D_REQ = 1; F_ADDR = 8'd6; D_ADDR = 8'd1;
    F_RREADY = 1; D_RREADY = 1;
    #1 chk("post_reset_f_first", F_GNT, 1);
    step();
    F_REQ = 0; D_REQ = 0;
    step();
    step();

    // Random traffic; a request holds its address until granted.
    f_hold = 0; d_hold = 0;
    for (int n = 0; n < 600; n++) begin
      if (!f_hold) begin
        F_REQ  = ($urandom_range(0, 3) != 0);
        F_ADDR = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      end
      if (!d_hold) begin
        D_REQ  = ($urandom_range(0, 3) != 0);
        D_ADDR = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      end
      F_RREADY = ($urandom_range(0, 3) != 0);
      D_RREADY = ($urandom_range(0, 3) != 0);
      step();
      f_hold = F_REQ && (m_win != 1);
      d_hold = D_REQ && (m_win != 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
